// File: rtl/fdtd_sched_pkg.sv
// Shared types for the FDTD timestep scheduler.
// States, DMA opcodes and default widths.
package fdtd_sched_pkg;

  localparam int STEP_W = 16;
  localparam int WDT_W  = 12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_HY,
    S_LD_EZ,
    S_C_HY,
    S_ST_HY,
    S_C_EZ,
    S_C_SRC,
    S_ST_EZ,
    S_NEXT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    LD_HY = 2'd0,
    LD_EZ = 2'd1,
    ST_HY = 2'd2,
    ST_EZ = 2'd3
  } dma_op_t;

  function automatic logic is_wait(input state_t s);
    return s inside {S_LD_HY, S_LD_EZ, S_C_HY, S_ST_HY,
                     S_C_EZ, S_C_SRC, S_ST_EZ};
  endfunction

endpackage

// File: rtl/fdtd_sched_wdt.sv
// Watchdog for the FDTD scheduler wait states.
// Used only when FDTD_SCHED_WDT_EN is defined.
module fdtd_sched_wdt
  import fdtd_sched_pkg::*;
#(
  parameter int WDT_W = fdtd_sched_pkg::WDT_W
) (
  input  logic   clk,
  input  logic   rst_n,
  input  state_t state,
  output logic   expired
);

  state_t           prev;
  logic [WDT_W-1:0] cnt;
  logic [WDT_W-1:0] eff;
  logic             waiting;

  // eff counts cycles spent in the current state, this one included
  always_comb begin
    waiting = is_wait(state);
    eff     = (state != prev) ? WDT_W'(1) : cnt + 1'b1;
    expired = waiting && (eff == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= S_IDLE;
      cnt  <= '0;
    end else begin
      prev <= state;
      cnt  <= waiting ? eff : '0;
    end
  end

endmodule

// File: rtl/fdtd_step_sched.sv
// FDTD timestep scheduler: Yee-ordered load/calc/store per step.
// Optional watchdog: define FDTD_SCHED_WDT_EN.
module fdtd_step_sched
  import fdtd_sched_pkg::*;
#(
  parameter int STEP_W = fdtd_sched_pkg::STEP_W,
  parameter int WDT_W  = fdtd_sched_pkg::WDT_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [STEP_W-1:0] num_steps_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [STEP_W-1:0] step_cnt_o,
  output logic              buffer_hy_start_o,
  output logic              buffer_ez_start_o,
  output logic              buffer_hy_end_o,
  output logic              buffer_ez_end_o,
  output logic              calc_hy_flg_o,
  output logic              calc_ez_flg_o,
  output logic              calc_src_flg_o,
  output logic              mem_rd_hy_en_o,
  output logic              mem_rd_ez_en_o,
  output logic              mem_rd_end_o,
  input  logic              wrt_hy_start_i,
  input  logic              wrt_ez_start_i,
  input  logic              wrt_src_start_i,
  output logic              dma_req_o,
  output logic [1:0]        dma_op_o,
  input  logic              dma_done_i,
  output logic              error_o
);

  state_t            state;
  dma_op_t           op_q;
  logic [STEP_W-1:0] num_steps;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] cnt_inc;
  logic              wdt_trip;

  assign cnt_inc    = step_cnt + 1'b1;
  assign step_cnt_o = step_cnt;
  assign dma_op_o   = op_q;

`ifdef FDTD_SCHED_WDT_EN
  logic err;
  assign error_o = err;

  fdtd_sched_wdt #(
    .WDT_W (WDT_W)
  ) u_wdt (
    .clk     (CLK),
    .rst_n   (RST_N),
    .state   (state),
    .expired (wdt_trip)
  );
`else
  assign error_o  = 1'b0;
  assign wdt_trip = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state             <= S_IDLE;
      op_q              <= LD_HY;
      num_steps         <= '0;
      step_cnt          <= '0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      buffer_hy_start_o <= 1'b0;
      buffer_ez_start_o <= 1'b0;
      buffer_hy_end_o   <= 1'b0;
      buffer_ez_end_o   <= 1'b0;
      calc_hy_flg_o     <= 1'b0;
      calc_ez_flg_o     <= 1'b0;
      calc_src_flg_o    <= 1'b0;
      mem_rd_hy_en_o    <= 1'b0;
      mem_rd_ez_en_o    <= 1'b0;
      mem_rd_end_o      <= 1'b0;
      dma_req_o         <= 1'b0;
`ifdef FDTD_SCHED_WDT_EN
      err               <= 1'b0;
`endif
    end else begin
      done_o            <= 1'b0;
      buffer_hy_start_o <= 1'b0;
      buffer_ez_start_o <= 1'b0;
      buffer_hy_end_o   <= 1'b0;
      buffer_ez_end_o   <= 1'b0;
      calc_hy_flg_o     <= 1'b0;
      calc_ez_flg_o     <= 1'b0;
      calc_src_flg_o    <= 1'b0;
      mem_rd_end_o      <= 1'b0;
      if (abort_i || wdt_trip) begin
        state          <= S_IDLE;
        op_q           <= LD_HY;
        busy_o         <= 1'b0;
        dma_req_o      <= 1'b0;
        mem_rd_hy_en_o <= 1'b0;
        mem_rd_ez_en_o <= 1'b0;
`ifdef FDTD_SCHED_WDT_EN
        if (wdt_trip) err <= 1'b1;
`endif
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start_i) begin
              num_steps <= num_steps_i;
              step_cnt  <= '0;
              busy_o    <= 1'b1;
`ifdef FDTD_SCHED_WDT_EN
              err       <= 1'b0;
`endif
              if (num_steps_i != '0) begin
                state             <= S_LD_HY;
                buffer_hy_start_o <= 1'b1;
                dma_req_o         <= 1'b1;
                op_q              <= LD_HY;
              end else begin
                state  <= S_DONE;
                done_o <= 1'b1;
              end
            end
          end
          S_LD_HY: begin
            if (dma_done_i && dma_req_o) begin
              state             <= S_LD_EZ;
              dma_req_o         <= 1'b0;
              op_q              <= LD_EZ;
              buffer_hy_end_o   <= 1'b1;
              buffer_ez_start_o <= 1'b1;
            end
          end
          // request drops for one cycle between the two loads
          S_LD_EZ: begin
            if (!dma_req_o) begin
              dma_req_o <= 1'b1;
            end else if (dma_done_i) begin
              state           <= S_C_HY;
              dma_req_o       <= 1'b0;
              buffer_ez_end_o <= 1'b1;
              calc_hy_flg_o   <= 1'b1;
            end
          end
          S_C_HY: begin
            if (wrt_hy_start_i) begin
              state          <= S_ST_HY;
              mem_rd_hy_en_o <= 1'b1;
              dma_req_o      <= 1'b1;
              op_q           <= ST_HY;
            end
          end
          S_ST_HY: begin
            if (dma_done_i) begin
              state          <= S_C_EZ;
              mem_rd_end_o   <= 1'b1;
              mem_rd_hy_en_o <= 1'b0;
              dma_req_o      <= 1'b0;
              calc_ez_flg_o  <= 1'b1;
            end
          end
          S_C_EZ: begin
            if (wrt_ez_start_i) begin
              state          <= S_C_SRC;
              calc_src_flg_o <= 1'b1;
            end
          end
          S_C_SRC: begin
            if (wrt_src_start_i) begin
              state          <= S_ST_EZ;
              mem_rd_ez_en_o <= 1'b1;
              dma_req_o      <= 1'b1;
              op_q           <= ST_EZ;
            end
          end
          S_ST_EZ: begin
            if (dma_done_i) begin
              state          <= S_NEXT;
              mem_rd_end_o   <= 1'b1;
              mem_rd_ez_en_o <= 1'b0;
              dma_req_o      <= 1'b0;
            end
          end
          S_NEXT: begin
            step_cnt <= cnt_inc;
            if (cnt_inc == num_steps) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              state             <= S_LD_HY;
              buffer_hy_start_o <= 1'b1;
              dma_req_o         <= 1'b1;
              op_q              <= LD_HY;
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
